// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin arbiter sharing one 4-bit ALU datapath among NREQ
// requesters. It grants a requester, drives the ALU and holds its inputs for ALU_WAIT
// cycles, captures the result, and returns it on a valid/ready response channel.
// Optional build macro ALU_SCHED_STATS_EN adds saturating stat_ops / stat_stall counters.
module alu_req_scheduler #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned ALU_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op_in,
  input  logic [4*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_y,
  output logic              rsp_flag,
  output logic [1:0]        alu_s,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  input  logic [3:0]        alu_y0,
  input  logic [3:0]        alu_y1,
  input  logic [3:0]        alu_y2,
  input  logic [3:0]        alu_y3,
  input  logic              alu_cout,
`ifdef ALU_SCHED_STATS_EN
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_stall,
`endif
  input  logic              alu_sign
);

  localparam int unsigned CNTW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [CNTW-1:0]   cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [3:0]        rsp_y_q;
  logic              rsp_flag_q;
  logic [1:0]        alu_s_q;
  logic [3:0]        alu_a_q;
  logic [3:0]        alu_b_q;

  logic              win_found_c;
  logic [IDW-1:0]    win_idx_c;
  logic [1:0]        op_sel_c;
  logic [3:0]        a_sel_c;
  logic [3:0]        b_sel_c;
  logic [3:0]        alu_y_c;
  logic              flag_c;
  logic [IDW-1:0]    ptr_next_c;

  // Round-robin pick: first set request at or after the pointer, wrapping to 0
  always_comb begin
    int unsigned idx;
    win_found_c = 1'b0;
    win_idx_c   = '0;
    idx         = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found_c && ((req & (NREQ'(1) << idx)) != '0)) begin
        win_found_c = 1'b1;
        win_idx_c   = IDW'(idx);
      end
    end
  end

  // Operand slices of the winning requester
  always_comb begin
    op_sel_c = 2'(op_in >> (32'(win_idx_c) * 32'd2));
    a_sel_c  = 4'(a_in >> (32'(win_idx_c) * 32'd4));
    b_sel_c  = 4'(b_in >> (32'(win_idx_c) * 32'd4));
  end

  // Result and flag selection for the op currently driven on the ALU
  always_comb begin
    alu_y_c = alu_y3;
    flag_c  = 1'b0;
    case (alu_s_q)
      2'd0: begin alu_y_c = alu_y0; flag_c = alu_cout; end
      2'd1: begin alu_y_c = alu_y1; flag_c = alu_sign; end
      2'd2: alu_y_c = alu_y2;
      default: alu_y_c = alu_y3;
    endcase
  end

  // Pointer moves to the slot after the winner once its response is taken
  always_comb begin
    ptr_next_c = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + IDW'(1);
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_flag_q  <= 1'b0;
      alu_s_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_found_c) begin
            gnt_q    <= NREQ'(1) << win_idx_c;
            rsp_id_q <= win_idx_c;
            alu_s_q  <= op_sel_c;
            alu_a_q  <= a_sel_c;
            alu_b_q  <= b_sel_c;
            cnt_q    <= CNTW'(ALU_WAIT - 1);
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            rsp_y_q     <= alu_y_c;
            rsp_flag_q  <= flag_c;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= ptr_next_c;
            alu_s_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flag  = rsp_flag_q;
  assign alu_s     = alu_s_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] stat_ops_q;
  logic [15:0] stat_stall_q;

  // Saturating counters: completed handshakes and back-pressured response cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else if (state_q == RESP) begin
      if (rsp_ready && stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (!rsp_ready && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: behavioural ALU, directed scenarios and a randomized
// transaction loop checked against a pointer/queue-level arbitration model.
module tb_alu_req_scheduler;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned ALU_WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] op_in;
  logic [15:0] a_in, b_in;
  logic [3:0] gnt;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [3:0] rsp_y;
  logic rsp_flag;
  logic [1:0] alu_s;
  logic [3:0] alu_a, alu_b;
  logic [3:0] alu_y0, alu_y1, alu_y2, alu_y3;
  logic alu_cout, alu_sign;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] stat_ops, stat_stall;
`endif

  logic [1:0] op_arr[4];
  logic [3:0] a_arr[4];
  logic [3:0] b_arr[4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_ptr = 0;

  assign op_in = {op_arr[3], op_arr[2], op_arr[1], op_arr[0]};
  assign a_in  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign b_in  = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  // Behavioural ALU: add, sub, compare {gt,eq}, and
  assign alu_y0   = alu_a + alu_b;
  assign alu_cout = ({1'b0, alu_a} + {1'b0, alu_b}) > 5'd15;
  assign alu_y1   = alu_a - alu_b;
  assign alu_sign = alu_a < alu_b;
  assign alu_y2   = {2'b00, alu_a > alu_b, alu_a == alu_b};
  assign alu_y3   = alu_a & alu_b;

  alu_req_scheduler #(.NREQ(NREQ), .IDW(IDW), .ALU_WAIT(ALU_WAIT)) dut (
    .clk(clk), .rst(rst), .req(req), .op_in(op_in), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_flag(rsp_flag), .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y0(alu_y0), .alu_y1(alu_y1), .alu_y2(alu_y2), .alu_y3(alu_y3),
    .alu_cout(alu_cout),
`ifdef ALU_SCHED_STATS_EN
    .stat_ops(stat_ops), .stat_stall(stat_stall),
`endif
    .alu_sign(alu_sign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {flag, y} from integer arithmetic
  function automatic logic [4:0] alu_ref(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int s;
    case (op)
      2'd0: begin s = int'(a) + int'(b); return {(s > 15) ? 1'b1 : 1'b0, 4'(s % 16)}; end
      2'd1: begin s = int'(a) - int'(b); return {(s < 0) ? 1'b1 : 1'b0, 4'((s + 16) % 16)}; end
      2'd2: return {1'b0, 2'b00, (a > b) ? 1'b1 : 1'b0, (a == b) ? 1'b1 : 1'b0};
      default: return {1'b0, a & b};
    endcase
  endfunction

  // Round-robin reference: first set request scanning from the pointer
  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (p + k) % 4;
      if (((r >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin op_arr[i] = '0; a_arr[i] = '0; b_arr[i] = '0; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic drain();
    req = '0;
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt, rsp_valid, rsp_id, rsp_y, rsp_flag, alu_s, alu_a, alu_b} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0",
               {gnt, rsp_valid, rsp_id, rsp_y, rsp_flag, alu_s, alu_a, alu_b});
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'd0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req gnt %b valid %b exp 0 0", gnt, rsp_valid);
    end
  endtask

  task automatic test_basic_add();
    do_reset();
    op_arr[0] = 2'd0; a_arr[0] = 4'd9; b_arr[0] = 4'd8;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL add_gnt got %b exp 0001", gnt); end
    checks++;
    if ({alu_s, alu_a, alu_b} !== {2'd0, 4'd9, 4'd8}) begin
      errors++; $display("FAIL add_alu_in got %h exp 098", {alu_s, alu_a, alu_b});
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'd0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_gnt_pulse gnt %b valid %b exp 0000 0", gnt, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_y, rsp_flag} !== {1'b1, 2'd0, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL add_rsp got v%b id%0d y%0d f%b exp v1 id0 y1 f1",
               rsp_valid, rsp_id, rsp_y, rsp_flag);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || {alu_s, alu_a, alu_b} !== 10'd0) begin
      errors++;
      $display("FAIL add_back_idle valid %b alu %h exp 0 000", rsp_valid, {alu_s, alu_a, alu_b});
    end
  endtask

  task automatic test_round_robin();
    int w;
    int last;
    logic [3:0] eg;
    logic [4:0] ex;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      op_arr[i] = 2'd3; a_arr[i] = 4'($urandom_range(0, 15)); b_arr[i] = 4'($urandom_range(0, 15));
    end
    req = 4'b1111;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      @(negedge clk);
      while (gnt === 4'd0 && w < 10) begin @(negedge clk); w++; end
      eg = 4'b0001 << (k % 4);
      checks++;
      if (gnt !== eg) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", k, gnt, eg); end
      if (k > 0) begin
        checks++;
        if (cyc - last != int'(ALU_WAIT) + 2) begin
          errors++; $display("FAIL rr_period%0d got %0d exp %0d", k, cyc - last, ALU_WAIT + 2);
        end
      end
      last = cyc;
      w = 0;
      while (rsp_valid !== 1'b1 && w < 10) begin @(negedge clk); w++; end
      ex = alu_ref(2'd3, a_arr[k % 4], b_arr[k % 4]);
      checks++;
      if ({rsp_valid, rsp_id, rsp_flag, rsp_y} !== {1'b1, 2'(k % 4), ex}) begin
        errors++;
        $display("FAIL rr_rsp%0d got v%b id%0d f%b y%0d exp v1 id%0d f%b y%0d",
                 k, rsp_valid, rsp_id, rsp_flag, rsp_y, k % 4, ex[4], ex[3:0]);
      end
    end
    drain();
  endtask

  task automatic test_sub_req2();
    logic [4:0] ex;
    do_reset();
    op_arr[2] = 2'd1; a_arr[2] = 4'd3; b_arr[2] = 4'd5;
    ex = alu_ref(2'd1, 4'd3, 4'd5);
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || {alu_s, alu_a, alu_b} !== {2'd1, 4'd3, 4'd5}) begin
      errors++;
      $display("FAIL sub_gnt gnt %b alu %h exp 0100 135", gnt, {alu_s, alu_a, alu_b});
    end
    req = '0;
    @(negedge clk);
    checks++;
    if ({alu_s, alu_a, alu_b} !== {2'd1, 4'd3, 4'd5}) begin
      errors++; $display("FAIL sub_hold alu %h exp 135", {alu_s, alu_a, alu_b});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_flag, rsp_y} !== {1'b1, 2'd2, ex}) begin
      errors++;
      $display("FAIL sub_rsp got v%b id%0d f%b y%0d exp v1 id2 f%b y%0d",
               rsp_valid, rsp_id, rsp_flag, rsp_y, ex[4], ex[3:0]);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [6:0] snap;
    do_reset();
    op_arr[0] = 2'($urandom_range(0, 3)); a_arr[0] = 4'($urandom_range(0, 15));
    b_arr[0] = 4'($urandom_range(0, 15));
    op_arr[1] = 2'($urandom_range(0, 3)); a_arr[1] = 4'($urandom_range(0, 15));
    b_arr[1] = 4'($urandom_range(0, 15));
    req = 4'b0011;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL stall_gnt0 got %b exp 0001", gnt); end
    @(negedge clk);
    @(negedge clk);
    snap = {alu_ref(op_arr[0], a_arr[0], b_arr[0]), 2'd0};
    checks++;
    if ({rsp_flag, rsp_y, rsp_id} !== snap || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL stall_rsp got %h v%b exp %h v1", {rsp_flag, rsp_y, rsp_id}, rsp_valid, snap);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_flag, rsp_y, rsp_id} !== snap || gnt !== 4'd0) begin
        errors++;
        $display("FAIL stall_hold%0d v%b rsp %h gnt %b exp v1 %h 0000",
                 k, rsp_valid, {rsp_flag, rsp_y, rsp_id}, gnt, snap);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || gnt !== 4'd0) begin
      errors++; $display("FAIL stall_hs v%b gnt %b exp 0 0000", rsp_valid, gnt);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL stall_next_gnt got %b exp 0010", gnt); end
    drain();
  endtask

  task automatic test_reset_exec();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL rexec_gnt got %b exp 0100", gnt); end
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, rsp_valid, rsp_id, rsp_y, rsp_flag, alu_s, alu_a, alu_b} !== 22'd0) begin
      errors++;
      $display("FAIL rexec_clear got %h exp 0",
               {gnt, rsp_valid, rsp_id, rsp_y, rsp_flag, alu_s, alu_a, alu_b});
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || gnt !== 4'd0) begin
        errors++; $display("FAIL rexec_quiet%0d v%b gnt %b exp 0 0000", k, rsp_valid, gnt);
      end
    end
    req = 4'b1010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL rexec_regrant got %b exp 0010", gnt); end
    drain();
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] eg;
    logic [4:0] ex;
    int win;
    int lat;
    int stall;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        op_arr[i] = 2'($urandom_range(0, 3));
        a_arr[i]  = 4'($urandom_range(0, 15));
        b_arr[i]  = 4'($urandom_range(0, 15));
      end
      r = 4'($urandom_range(0, 15));
      if (r == 4'd0) begin
        req = '0;
        rsp_ready = 1'($urandom_range(0, 1));
        repeat (2) begin
          @(negedge clk);
          checks++;
          if (gnt !== 4'd0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_idle%0d gnt %b v%b exp 0000 0", t, gnt, rsp_valid);
          end
        end
        r = 4'($urandom_range(1, 15));
      end
      req = r;
      rsp_ready = 1'($urandom_range(0, 1));
      win = model_pick(r, m_ptr);
      eg = 4'b0001 << win;
      ex = alu_ref(op_arr[win], a_arr[win], b_arr[win]);
      @(negedge clk);
      checks++;
      if (gnt !== eg || {alu_s, alu_a, alu_b} !== {op_arr[win], a_arr[win], b_arr[win]}) begin
        errors++;
        $display("FAIL rnd_gnt%0d gnt %b alu %h exp %b %h", t, gnt, {alu_s, alu_a, alu_b},
                 eg, {op_arr[win], a_arr[win], b_arr[win]});
      end
      req = 4'($urandom_range(0, 15));
      lat = 0;
      do begin @(negedge clk); lat++; end while (rsp_valid !== 1'b1 && lat < 10);
      checks++;
      if (lat != int'(ALU_WAIT) || {rsp_id, rsp_flag, rsp_y} !== {2'(win), ex}) begin
        errors++;
        $display("FAIL rnd_rsp%0d lat %0d id%0d f%b y%0d exp lat %0d id%0d f%b y%0d", t, lat,
                 rsp_id, rsp_flag, rsp_y, ALU_WAIT, win, ex[4], ex[3:0]);
      end
      stall = $urandom_range(0, 3);
      rsp_ready = (stall == 0);
      while (stall > 0) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_flag, rsp_y} !== {2'(win), ex} || gnt !== 4'd0) begin
          errors++;
          $display("FAIL rnd_hold%0d v%b rsp %h gnt %b", t, rsp_valid, {rsp_id, rsp_flag, rsp_y}, gnt);
        end
        stall--;
        rsp_ready = (stall == 0);
      end
      req = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_hs%0d v%b exp 0", t, rsp_valid); end
      m_ptr = (win + 1) % 4;
    end
    drain();
  endtask

`ifdef ALU_SCHED_STATS_EN
  task automatic test_stats();
    int st[3];
    st[0] = 1; st[1] = 1; st[2] = 2;
    do_reset();
    for (int o = 0; o < 4; o++) begin
      if (o == 3) begin
        force dut.stat_ops_q = 16'hFFFF;
        force dut.stat_stall_q = 16'hFFFF;
        @(negedge clk);
        release dut.stat_ops_q;
        release dut.stat_stall_q;
      end
      req = 4'b0001;
      @(negedge clk);
      req = '0;
      @(negedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      repeat ((o < 3) ? st[o] : 1) @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      if (o == 2) begin
        checks++;
        if (stat_ops !== 16'd3 || stat_stall !== 16'd4) begin
          errors++; $display("FAIL stats_count ops %0d stall %0d exp 3 4", stat_ops, stat_stall);
        end
      end
    end
    checks++;
    if (stat_ops !== 16'hFFFF || stat_stall !== 16'hFFFF) begin
      errors++; $display("FAIL stats_sat ops %h stall %h exp ffff ffff", stat_ops, stat_stall);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_round_robin();
    test_sub_req2();
    test_stall();
    test_reset_exec();
    test_random();
`ifdef ALU_SCHED_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
